// File: rtl/wb_stage_mc.sv
// -----------------------------------------------------------------------------
// wb_stage_mc
// Registered writeback stage for the three-stage RISC-V pipeline.
// It picks the register-file write value from one of four sources: the
// immediate, PC+4, aligned load data, or the ALU result. Load data comes from
// NSRC memory sources, and each source can take a different number of cycles
// to answer. While a load is outstanding the stage waits in a small FSM and
// holds the upstream stages. A timeout counter aborts any load that never gets
// a response.
//
// Optional feature (macro WB_STATS_EN): adds two free-running 32-bit counters,
// retire_cnt and stall_cnt.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  handshake with the EXE stage
//   instruction          raw instruction word (0 marks a bubble)
//   pc, imm, alu         PC, immediate, ALU result / load address
//   rd                   destination register
//   wb_sel               0=IMM, 1=PC+4, 2=MEM, 3=ALU
//   load_type            load funct3 (LB, LH, LW, LD, LBU, LHU, LWU)
//   mem_sel              load source index
//   mem_rdata            concatenated source data, source k at [k*XLEN +: XLEN]
//   mem_rvalid           per-source response valid
//   wb_we, wb_rd, wb_data  registered register-file write port
//   stall                upstream hold while a load is outstanding
//   load_err             one-cycle pulse on timeout, misalignment or bad source
//   retire_cnt, stall_cnt  statistics counters (WB_STATS_EN only)
// -----------------------------------------------------------------------------
module wb_stage_mc #(
    parameter int XLEN    = 32,
    parameter int NSRC    = 3,
    parameter int SRC_W   = (NSRC > 1) ? $clog2(NSRC) : 1,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            instruction,
    input  logic [XLEN-1:0]        pc,
    input  logic [XLEN-1:0]        imm,
    input  logic [XLEN-1:0]        alu,
    input  logic [4:0]             rd,
    input  logic [1:0]             wb_sel,
    input  logic [2:0]             load_type,
    input  logic [SRC_W-1:0]       mem_sel,
    input  logic [NSRC*XLEN-1:0]   mem_rdata,
    input  logic [NSRC-1:0]        mem_rvalid,
    output logic                   wb_we,
    output logic [4:0]             wb_rd,
    output logic [XLEN-1:0]        wb_data,
    output logic                   stall,
    output logic                   load_err
`ifdef WB_STATS_EN
    ,
    output logic [31:0]            retire_cnt,
    output logic [31:0]            stall_cnt
`endif
);

    localparam int OFFW  = $clog2(XLEN / 8);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        S_IDLE,
        S_WAIT_LOAD
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_count;
    logic [OFFW-1:0]     r_cap_off;
    logic [2:0]          r_cap_type;
    logic [SRC_W-1:0]    r_cap_sel;
    logic [4:0]          r_cap_rd;
    logic                r_cap_we;

    logic                r_wb_we;
    logic [4:0]          r_wb_rd;
    logic [XLEN-1:0]     r_wb_data;
    logic                r_load_err;

    logic [SRC_W-1:0]    w_sel;
    logic [OFFW-1:0]     w_off;
    logic [2:0]          w_type;
    logic [XLEN-1:0]     w_raw;
    logic                w_rvalid;
    logic                w_in_range;
    logic [OFFW-1:0]     w_off_h;
    logic [OFFW-1:0]     w_off_w;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_word;
    logic [XLEN-1:0]     w_ld_data;
    logic                w_ld_err;
    logic                w_in_we;

    logic                w_new_we;
    logic [4:0]          w_new_rd;
    logic [XLEN-1:0]     w_new_data;
    logic                w_new_err;
    logic                w_capture;

    assign in_ready = (r_state == S_IDLE);
    assign stall    = (r_state == S_WAIT_LOAD);
    assign wb_we    = r_wb_we;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;
    assign load_err = r_load_err;

    // A bubble or a write to x0 still moves through the stage, but it must
    // never reach the register file.
    assign w_in_we = (instruction != 32'd0) && (rd != 5'd0);

    // While waiting, the load is steered by the captured fields. In IDLE the
    // live inputs are used so that a same-cycle response completes at once.
    always_comb begin
        w_sel      = (r_state == S_WAIT_LOAD) ? r_cap_sel  : mem_sel;
        w_off      = (r_state == S_WAIT_LOAD) ? r_cap_off  : alu[OFFW-1:0];
        w_type     = (r_state == S_WAIT_LOAD) ? r_cap_type : load_type;
        w_raw      = '0;
        w_rvalid   = 1'b0;
        w_in_range = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (w_sel == SRC_W'(k)) begin
                w_raw      = mem_rdata[k*XLEN +: XLEN];
                w_rvalid   = mem_rvalid[k];
                w_in_range = 1'b1;
            end
        end
    end

    // Byte-lane alignment. A misaligned access reads the aligned container
    // (the low offset bits are dropped) and is flagged as an error.
    always_comb begin
        w_off_h   = w_off & ~OFFW'(1);
        w_off_w   = w_off & ~OFFW'(3);
        w_byte    = 8'(w_raw >> {w_off, 3'b000});
        w_half    = 16'(w_raw >> {w_off_h, 3'b000});
        w_word    = 32'(w_raw >> {w_off_w, 3'b000});
        w_ld_data = w_raw;
        w_ld_err  = 1'b0;
        case (w_type)
            3'b000: w_ld_data = XLEN'($signed(w_byte));
            3'b100: w_ld_data = XLEN'(w_byte);
            3'b001: begin
                w_ld_data = XLEN'($signed(w_half));
                w_ld_err  = w_off[0];
            end
            3'b101: begin
                w_ld_data = XLEN'(w_half);
                w_ld_err  = w_off[0];
            end
            3'b010: begin
                w_ld_data = XLEN'($signed(w_word));
                w_ld_err  = (w_off[1:0] != 2'b00);
            end
            3'b110: begin
                w_ld_data = XLEN'(w_word);
                w_ld_err  = (w_off[1:0] != 2'b00);
            end
            3'b011: begin
                if (XLEN == 64) begin
                    w_ld_data = w_raw;
                    w_ld_err  = (w_off != '0);
                end else begin
                    w_ld_data = XLEN'($signed(w_word));
                    w_ld_err  = (w_off[1:0] != 2'b00);
                end
            end
            default: begin
                w_ld_data = w_raw;
                w_ld_err  = 1'b0;
            end
        endcase
    end

    // Next-state and writeback selection. With no write, wb_we falls back to 0
    // while the rd and data registers hold their last values.
    always_comb begin
        w_next_state = r_state;
        w_new_we     = 1'b0;
        w_new_rd     = r_wb_rd;
        w_new_data   = r_wb_data;
        w_new_err    = 1'b0;
        w_capture    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_new_we = w_in_we;
                    w_new_rd = rd;
                    unique case (wb_sel)
                        2'd0: w_new_data = imm;
                        2'd1: w_new_data = pc + XLEN'(4);
                        2'd2: begin
                            if (!w_in_range) begin
                                w_new_data = '0;
                                w_new_err  = 1'b1;
                            end else if (w_rvalid) begin
                                w_new_data = w_ld_data;
                                w_new_err  = w_ld_err;
                            end else begin
                                w_new_we     = 1'b0;
                                w_new_rd     = r_wb_rd;
                                w_capture    = 1'b1;
                                w_next_state = S_WAIT_LOAD;
                            end
                        end
                        default: w_new_data = alu;
                    endcase
                end
            end
            S_WAIT_LOAD: begin
                if (w_rvalid) begin
                    w_new_we     = r_cap_we;
                    w_new_rd     = r_cap_rd;
                    w_new_data   = w_ld_data;
                    w_new_err    = w_ld_err;
                    w_next_state = S_IDLE;
                end else if (r_count == CNT_W'(TIMEOUT)) begin
                    w_new_we     = r_cap_we;
                    w_new_rd     = r_cap_rd;
                    w_new_data   = '0;
                    w_new_err    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State, capture registers, timeout counter and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_cap_off  <= '0;
            r_cap_type <= '0;
            r_cap_sel  <= '0;
            r_cap_rd   <= '0;
            r_cap_we   <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wb_we    <= w_new_we;
            r_wb_rd    <= w_new_rd;
            r_wb_data  <= w_new_data;
            r_load_err <= w_new_err;
            if (w_capture) begin
                r_cap_off  <= alu[OFFW-1:0];
                r_cap_type <= load_type;
                r_cap_sel  <= mem_sel;
                r_cap_rd   <= rd;
                r_cap_we   <= w_in_we;
                r_count    <= '0;
            end else if (r_state == S_WAIT_LOAD) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

`ifdef WB_STATS_EN
    logic [31:0] r_retire_cnt;
    logic [31:0] r_stall_cnt;

    // Statistics counters; both wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (r_wb_we) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
            if (r_state == S_WAIT_LOAD) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign retire_cnt = r_retire_cnt;
    assign stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_wb_stage_mc.sv
// -----------------------------------------------------------------------------
// tb_wb_stage_mc
// Self-checking bench for wb_stage_mc (XLEN=32, NSRC=3, TIMEOUT=4).
// A table of single-cycle vectors covers the non-load sources, same-cycle
// load responses, alignment, misalignment and an out-of-range source.
// Hand-written sequences cover the multi-cycle load, the timeout, a late
// response and reset in the middle of a load.
// -----------------------------------------------------------------------------
module tb_wb_stage_mc;

    localparam int XLEN  = 32;
    localparam int NSRC  = 3;
    localparam int SRC_W = 2;
    localparam int TO    = 4;

    logic                  clk = 1'b0;
    logic                  rstN;
    logic                  inValid;
    logic                  inReady;
    logic [31:0]           instruction;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       alu;
    logic [4:0]            rd;
    logic [1:0]            wbSel;
    logic [2:0]            loadType;
    logic [SRC_W-1:0]      memSel;
    logic [NSRC*XLEN-1:0]  memRdata;
    logic [NSRC-1:0]       memRvalid;
    logic                  wbWe;
    logic [4:0]            wbRd;
    logic [XLEN-1:0]       wbData;
    logic                  stall;
    logic                  loadErr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [1:0]  wbSel;
        logic [2:0]  loadType;
        logic [1:0]  memSel;
        logic [31:0] rdata;
        logic [2:0]  rvalid;
        logic        expWe;
        logic [4:0]  expRd;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;

    vec_t vecQ[$];

    wb_stage_mc #(
        .XLEN    (XLEN),
        .NSRC    (NSRC),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rstN),
        .in_valid    (inValid),
        .in_ready    (inReady),
        .instruction (instruction),
        .pc          (pc),
        .imm         (imm),
        .alu         (alu),
        .rd          (rd),
        .wb_sel      (wbSel),
        .load_type   (loadType),
        .mem_sel     (memSel),
        .mem_rdata   (memRdata),
        .mem_rvalid  (memRvalid),
        .wb_we       (wbWe),
        .wb_rd       (wbRd),
        .wb_data     (wbData),
        .stall       (stall),
        .load_err    (loadErr)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pcV,
                                input logic [31:0] immV, input logic [31:0] aluV,
                                input logic [4:0] rdV, input logic [1:0] sel,
                                input logic [2:0] lt, input logic [1:0] ms,
                                input logic [31:0] rdata, input logic [2:0] rv,
                                input logic eWe, input logic [4:0] eRd,
                                input logic [31:0] eData, input logic eErr);
        vec_t v;
        v.instr = instr; v.pc = pcV; v.imm = immV; v.alu = aluV; v.rd = rdV;
        v.wbSel = sel; v.loadType = lt; v.memSel = ms; v.rdata = rdata;
        v.rvalid = rv; v.expWe = eWe; v.expRd = eRd; v.expData = eData;
        v.expErr = eErr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        inValid     = 1'b1;
        instruction = v.instr;
        pc          = v.pc;
        imm         = v.imm;
        alu         = v.alu;
        rd          = v.rd;
        wbSel       = v.wbSel;
        loadType    = v.loadType;
        memSel      = v.memSel;
        memRdata    = {3{32'hDEADBEEF}};
        if (v.memSel < 2'd3) memRdata[int'(v.memSel)*32 +: 32] = v.rdata;
        memRvalid   = v.rvalid;
    endtask

    task automatic idleInputs();
        inValid   = 1'b0;
        memRvalid = '0;
    endtask

    // LB/LBU from DMEM at 0x103, with the answer arriving in the third wait
    // cycle. A response from a different source in the first wait cycle
    // must not end the load.
    task automatic runSlowLoad(input logic [2:0] lt, input logic [31:0] expData,
                               input string name);
        int stallCycles;
        stallCycles = 0;
        applyStimulus(mk(32'h00358603, 0, 0, 32'h00000103, 5'd12, 2'd2, lt, 2'd1,
                         32'h0, 3'b000, 0, 0, 0, 0));
        @(negedge clk);
        idleInputs();
        if (stall) stallCycles++;
        checkOutput({name, "_w1_ready"}, inReady, 0);
        checkOutput({name, "_w1_we"}, wbWe, 0);
        memRvalid = 3'b001;
        memRdata[31:0] = 32'h11111111;
        @(negedge clk);
        if (stall) stallCycles++;
        checkOutput({name, "_w2_stall"}, stall, 1);
        memRvalid = 3'b000;
        @(negedge clk);
        if (stall) stallCycles++;
        memRvalid = 3'b010;
        memRdata[63:32] = 32'h80FF0000;
        @(negedge clk);
        memRvalid = 3'b000;
        checkOutput({name, "_stall_cycles"}, stallCycles, 3);
        checkOutput({name, "_stall_after"}, stall, 0);
        checkOutput({name, "_ready_after"}, inReady, 1);
        checkOutput({name, "_we"}, wbWe, 1);
        checkOutput({name, "_rd"}, wbRd, 12);
        checkOutput({name, "_data"}, wbData, expData);
        checkOutput({name, "_err"}, loadErr, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stallCycles;
        rstN        = 1'b0;
        inValid     = 1'b0;
        instruction = '0;
        pc          = '0;
        imm         = '0;
        alu         = '0;
        rd          = '0;
        wbSel       = '0;
        loadType    = '0;
        memSel      = '0;
        memRdata    = '0;
        memRvalid   = '0;

        // Vectors: instr, pc, imm, alu, rd, wbSel, loadType, memSel, rdata,
        // rvalid, expWe, expRd, expData, expErr
        vecQ.push_back(mk(32'h00B50533, 0, 0, 32'h12345678, 10, 3, 0, 0, 0, 0, 1, 10, 32'h12345678, 0));
        vecQ.push_back(mk(32'h008000EF, 32'hFFFFFFFC, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 32'h00000000, 0));
        vecQ.push_back(mk(32'hABCDE2B7, 0, 32'hABCDE000, 0, 5, 0, 0, 0, 0, 0, 1, 5, 32'hABCDE000, 0));
        vecQ.push_back(mk(32'h00000000, 0, 0, 32'h00000055, 10, 3, 0, 0, 0, 0, 0, 10, 32'h00000055, 0));
        vecQ.push_back(mk(32'h00000033, 0, 0, 32'h00000077, 0, 3, 0, 0, 0, 0, 0, 0, 32'h00000077, 0));
        vecQ.push_back(mk(32'h0025D503, 0, 0, 32'h00000102, 10, 2, 3'b101, 1, 32'hBEEF1234, 3'b010, 1, 10, 32'h0000BEEF, 0));
        vecQ.push_back(mk(32'h00259503, 0, 0, 32'h00000102, 11, 2, 3'b001, 1, 32'hBEEF1234, 3'b010, 1, 11, 32'hFFFFBEEF, 0));
        vecQ.push_back(mk(32'h00150503, 0, 0, 32'h00000001, 6, 2, 3'b000, 0, 32'h11227F33, 3'b001, 1, 6, 32'h0000007F, 0));
        vecQ.push_back(mk(32'h0005A503, 0, 0, 32'h00000200, 7, 2, 3'b010, 2, 32'h89ABCDEF, 3'b100, 1, 7, 32'h89ABCDEF, 0));
        vecQ.push_back(mk(32'h0025A503, 0, 0, 32'h00000202, 8, 2, 3'b010, 2, 32'h89ABCDEF, 3'b111, 1, 8, 32'h89ABCDEF, 1));
        vecQ.push_back(mk(32'h00359503, 0, 0, 32'h00000003, 9, 2, 3'b001, 0, 32'hBEEF1234, 3'b001, 1, 9, 32'hFFFFBEEF, 1));
        vecQ.push_back(mk(32'h0005B503, 0, 0, 32'h00000100, 14, 2, 3'b011, 1, 32'hCAFEF00D, 3'b010, 1, 14, 32'hCAFEF00D, 0));
        vecQ.push_back(mk(32'h0005A383, 0, 0, 32'h00000300, 7, 2, 3'b010, 3, 32'h0, 3'b000, 1, 7, 32'h00000000, 1));
        vecQ.push_back(mk(32'h0035C683, 0, 0, 32'h00000103, 13, 2, 3'b100, 1, 32'h80FF0000, 3'b010, 1, 13, 32'h00000080, 0));

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_we", wbWe, 0);
        checkOutput("reset_rd", wbRd, 0);
        checkOutput("reset_data", wbData, 0);
        checkOutput("reset_err", loadErr, 0);
        checkOutput("reset_ready", inReady, 1);
        checkOutput("reset_stall", stall, 0);
        rstN = 1'b1;
        @(negedge clk);

        // Single-cycle vectors, applied back to back.
        for (int i = 0; i < vecQ.size(); i++) begin
            applyStimulus(vecQ[i]);
            checkOutput($sformatf("v%0d_ready", i), inReady, 1);
            @(negedge clk);
            idleInputs();
            checkOutput($sformatf("v%0d_we", i), wbWe, vecQ[i].expWe);
            checkOutput($sformatf("v%0d_rd", i), wbRd, vecQ[i].expRd);
            checkOutput($sformatf("v%0d_data", i), wbData, vecQ[i].expData);
            checkOutput($sformatf("v%0d_err", i), loadErr, vecQ[i].expErr);
            checkOutput($sformatf("v%0d_stall", i), stall, 0);
        end

        // No accept: write enable drops, data holds.
        @(negedge clk);
        checkOutput("noacc_we", wbWe, 0);
        checkOutput("noacc_data", wbData, 32'h00000080);
        checkOutput("noacc_err", loadErr, 0);

        runSlowLoad(3'b000, 32'hFFFFFF80, "lb_slow");
        runSlowLoad(3'b100, 32'h00000080, "lbu_slow");

        // Timeout: LW from DMEM that never answers.
        applyStimulus(mk(32'h0000A483, 0, 0, 32'h00000100, 9, 2, 3'b010, 1,
                         32'h0, 3'b000, 0, 0, 0, 0));
        stallCycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) idleInputs();
            if (stall) stallCycles++;
            else break;
        end
        checkOutput("to_stall_cycles", stallCycles, TO + 1);
        checkOutput("to_ready", inReady, 1);
        checkOutput("to_we", wbWe, 1);
        checkOutput("to_rd", wbRd, 9);
        checkOutput("to_data", wbData, 0);
        checkOutput("to_err", loadErr, 1);
        memRvalid = 3'b010;
        memRdata[63:32] = 32'h12345678;
        @(negedge clk);
        memRvalid = 3'b000;
        checkOutput("late_we", wbWe, 0);
        checkOutput("late_err", loadErr, 0);
        checkOutput("late_data", wbData, 0);
        checkOutput("late_stall", stall, 0);

        // Reset in the middle of an outstanding load.
        applyStimulus(mk(32'h00B50533, 0, 0, 32'hA5A5A5A5, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkOutput("pre_rst_data", wbData, 32'hA5A5A5A5);
        applyStimulus(mk(32'h0000A203, 0, 0, 32'h00000200, 4, 2, 3'b010, 2,
                         32'h0, 3'b000, 0, 0, 0, 0));
        @(negedge clk);
        idleInputs();
        checkOutput("rst_wait_stall", stall, 1);
        checkOutput("rst_wait_we", wbWe, 0);
        checkOutput("rst_wait_data", wbData, 32'hA5A5A5A5);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("rst_mid_ready", inReady, 1);
        checkOutput("rst_mid_stall", stall, 0);
        checkOutput("rst_mid_we", wbWe, 0);
        checkOutput("rst_mid_rd", wbRd, 0);
        checkOutput("rst_mid_data", wbData, 0);
        checkOutput("rst_mid_err", loadErr, 0);
        @(negedge clk);
        rstN = 1'b1;
        memRvalid = 3'b100;
        memRdata[95:64] = 32'h76543210;
        @(negedge clk);
        memRvalid = 3'b000;
        checkOutput("post_rst_we", wbWe, 0);
        checkOutput("post_rst_stall", stall, 0);
        checkOutput("post_rst_data", wbData, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
